aud_play_sched: RTL
===================

// Module: aud_play_sched
// PURPOSE
//  Playback scheduler for the audio DAC serializer (the player).
//  - Walks SRAM sample addresses at the rate set by speed/mode.
//  - Latches one 16-bit sample per LRC frame and drives the player's data input and enable.
//  - Handles start/pause/stop commands and end-of-recording detection.
//  - Sits between the top-level control FSM and the player, on the same bit clock (BCLK).
// PARAMETERS
//  ADDR_W     20  SRAM word-address width
//  DATA_W     16  sample width (must match player)
//  MAX_SPEED   8  largest speed factor accepted; larger inputs are clamped to this
// PORTS
//  i_clk        in   1       BCLK; all logic on posedge
//  i_rst_n      in   1       reset, asynchronous, active-low
//  i_start      in   1       1-cycle pulse: begin/resume playback
//  i_pause      in   1       1-cycle pulse: freeze at current address
//  i_stop       in   1       1-cycle pulse: abort, rewind to address 0
//  i_fast       in   1       1 = skip samples; 0 = hold samples (slow)
//  i_speed      in   4       speed factor 1..MAX_SPEED; 0 is treated as 1
//  i_end_addr   in   ADDR_W  last valid sample address of the recording
//  i_lrc        in   1       DAC LRCK from codec
//  i_sram_data  in   DATA_W  SRAM read data for o_sram_addr (combinational SRAM read)
//  o_sram_addr  out  ADDR_W  current sample address (= addr_r)
//  o_dac_data   out  DATA_W  registered sample presented to player
//  o_player_en  out  1       player enable; high only in S_PLAY
//  o_state      out  2       S_IDLE=0, S_PLAY=1, S_PAUSE=2, S_DONE=3
//  o_done       out  1       1-cycle pulse when recording end is reached
// BEHAVIOUR
//  Reset values: state S_IDLE, addr 0, hold counter 0, o_dac_data 0, o_player_en 0, o_done 0.
//  Frame tick:
//   - lrc_d is i_lrc registered; tick = i_lrc & ~lrc_d (LRC rising edge, one cycle wide).
//   - Data therefore updates at the start of the right half-frame and is stable before LRC falls.
//  Speed: spd = (i_speed==0) ? 1 : min(i_speed, MAX_SPEED). Sampled at each tick.
//  FSM:
//   - S_IDLE:
//     - i_start -> S_PLAY. addr stays 0; hold cnt 0.
//   - S_PLAY, on each tick:
//     - o_dac_data <= i_sram_data. The sample for the current address appears one cycle after the tick.
//     - fast mode: next address = addr + spd. If that exceeds i_end_addr -> S_DONE instead of advancing.
//     - slow mode: hold cnt increments; when hold cnt == spd-1, clear it and advance addr by 1, with the same end check.
//     - i_pause -> S_PAUSE. addr, hold cnt and o_dac_data are kept.
//   - S_PAUSE:
//     - o_player_en 0; no ticks consumed.
//     - i_start -> S_PLAY, resuming at the held addr.
//   - S_DONE: for one cycle:
//     - o_done=1, o_player_en=0, o_dac_data<=0, addr<=0.
//     - Then -> S_IDLE unconditionally.
//  Command priority in the same cycle: i_stop > i_pause > i_start.
//   - i_stop in any state -> S_IDLE: addr 0, hold cnt 0, o_dac_data 0, o_player_en 0. No o_done.
//   - i_start in S_PLAY or S_DONE is ignored.
//  Simultaneous tick + command: the command wins and the tick is dropped (no address advance).
//  o_player_en is registered: 1 exactly while state==S_PLAY.
//   - The player handles re-synchronisation itself on enable edges.
//  Address arithmetic: computed in ADDR_W+1 bits so the end-check carry is not lost.
//   - i_end_addr == 0: a single sample plays, then S_DONE on the first advance.
//  Speed or mode change mid-play: takes effect at the next tick.
//   - Switching fast->slow clears hold cnt.
//  Asynchronous reset mid-frame: all outputs return to reset values immediately.
// STRUCTURE
//  Package aud_pkg:
//   - typedef enum logic [1:0] play_state_t {S_IDLE, S_PLAY, S_PAUSE, S_DONE}.
//   - localparams DATA_W=16, SPD_W=4.
//   - Shared with the player and the top FSM.
//  Sub-module lrc_edge_det: i_clk, i_rst_n, i_lrc -> o_rise, o_fall (1-cycle pulses).
//  Main module: single comb next-state block plus one async-reset always_ff.
// TESTING
//  1 Fast, spd=2, end=9, SRAM[a]=a*16'h0101
//    -> o_dac_data sequence 0000,0202,0404,0606,0808; o_done pulse after 5th tick; back in S_IDLE.
//  2 Slow, spd=3, end=2
//    -> each sample 0000,0101,0202 held exactly 3 ticks; o_done after 9th tick.
//  3 Pause at addr 4, then 5 LRC frames, then start
//    -> o_player_en low for all 5 frames, addr stays 4, playback resumes at 4.
//  4 i_stop and i_pause in the same cycle during play
//    -> S_IDLE, addr 0, o_dac_data 0, no o_done.
//  5 i_speed=0, then i_speed=12, fast mode
//    -> address steps of 1, then 8.
//  6 Assert i_rst_n low one cycle after a tick in S_PLAY
//    -> all outputs 0 immediately; i_start after release restarts at addr 0.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared types and constants for the audio playback path:
// scheduler, player and top-level control FSM.
package aud_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SPD_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } play_state_t;

  // A speed of 0 means 1; anything above max_spd saturates to max_spd.
  function automatic logic [SPD_W-1:0] clamp_speed(
    input logic [SPD_W-1:0] spd,
    input logic [SPD_W-1:0] max_spd
  );
    if (spd == '0) begin
      return SPD_W'(1);
    end
    if (spd > max_spd) begin
      return max_spd;
    end
    return spd;
  endfunction

endpackage

// File: rtl/lrc_edge_det.sv
// LRCK edge detector: registers LRCK and flags rising/falling edges
// as one-cycle pulses in the BCLK domain.
module lrc_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_lrc,
  output logic o_rise,
  output logic o_fall
);

  logic lrc_q;
  logic lrc_d;

  always_comb begin
    lrc_d = i_lrc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_q <= 1'b0;
    end else begin
      lrc_q <= lrc_d;
    end
  end

  assign o_rise = i_lrc & ~lrc_q;
  assign o_fall = ~i_lrc & lrc_q;

endmodule

// File: rtl/aud_play_sched.sv
// Playback scheduler: steps SRAM sample addresses once per LRC frame at the
// selected speed/mode and feeds one registered sample per frame to the player.
module aud_play_sched #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_SPEED = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic [3:0]        i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_lrc,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_player_en,
  output logic [1:0]        o_state,
  output logic              o_done
);

  import aud_pkg::*;

  localparam int unsigned      AW1     = ADDR_W + 1;
  localparam logic [SPD_W-1:0] MAX_SPD = SPD_W'(MAX_SPEED);

  play_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SPD_W-1:0]  hold_q, hold_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic              en_q, en_d;
  logic              done_q, done_d;

  logic              tick;
  logic              lrc_fall_unused;
  logic [SPD_W-1:0]  spd;
  logic [SPD_W-1:0]  step;
  logic [ADDR_W:0]   addr_nxt;
  logic              past_end;
  logic              advance;

  lrc_edge_det u_lrc_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_lrc   (i_lrc),
    .o_rise  (tick),
    .o_fall  (lrc_fall_unused)
  );

  always_comb begin
    spd      = clamp_speed(i_speed, MAX_SPD);
    step     = i_fast ? spd : SPD_W'(1);
    // One extra bit so a step past the top of the address space still reads as past-end.
    addr_nxt = {1'b0, addr_q} + AW1'(step);
    past_end = addr_nxt > {1'b0, i_end_addr};

    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = i_fast ? '0 : hold_q;
    dac_d   = dac_q;
    done_d  = 1'b0;
    advance = 1'b0;

    // Stop beats everything; otherwise pause beats start, and any command swallows a same-cycle tick.
    if (i_stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      hold_d  = '0;
      dac_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start && !i_pause) begin
            state_d = S_PLAY;
            addr_d  = '0;
            hold_d  = '0;
          end
        end
        S_PLAY: begin
          if (i_pause) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            dac_d   = i_sram_data;
            advance = 1'b1;
            if (!i_fast) begin
              if (hold_q < spd - SPD_W'(1)) begin
                hold_d  = hold_q + SPD_W'(1);
                advance = 1'b0;
              end else begin
                hold_d = '0;
              end
            end
            if (advance) begin
              if (past_end) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                addr_d = addr_nxt[ADDR_W-1:0];
              end
            end
          end
        end
        S_PAUSE: begin
          if (i_start && !i_pause) begin
            state_d = S_PLAY;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          addr_d  = '0;
          hold_d  = '0;
          dac_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    en_d = (state_d == S_PLAY);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      hold_q  <= '0;
      dac_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      dac_q   <= dac_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign o_sram_addr = addr_q;
  assign o_dac_data  = dac_q;
  assign o_player_en = en_q;
  assign o_state     = state_q;
  assign o_done      = done_q;

endmodule
